// File: rtl/code_memory_loader.sv
// Boot-time code memory loader: assembles a nibble stream into 16-bit words,
// writes them to code memory, holds the CPU fetch path and verifies a checksum.
module code_memory_loader #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned MAX_WORDS  = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_start,
  input  logic [3:0]            in_nibble,
  input  logic                  in_nibble_valid,
  output logic                  out_nibble_ready,
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_wr_addr,
  output logic [WORD_WIDTH-1:0] out_wr_data,
  output logic                  out_cpu_hold,
  output logic                  out_done,
  output logic                  out_error,
  output logic [ADDR_WIDTH:0]   out_word_count
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned LEN_W = 12;
  localparam int unsigned SUM_W = 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] CHK   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERROR = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [3:0]            chk_hi_q, chk_hi_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  ready_q, ready_d;
  logic                  accept_c;
  logic [CNT_W-1:0]      cnt_inc_c;

  assign accept_c  = in_nibble_valid && ready_q;
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // State and datapath registers; reset returns to IDLE with every output low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      word_q    <= '0;
      sum_q     <= '0;
      chk_hi_q  <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      word_q    <= word_d;
      sum_q     <= sum_d;
      chk_hi_q  <= chk_hi_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    word_d    = word_q;
    sum_d     = sum_q;
    chk_hi_d  = chk_hi_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    error_d   = error_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (in_start) begin
          state_d = LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
          idx_d   = '0;
          len_d   = '0;
        end
      end

      LEN: begin
        if (accept_c) begin
          len_d = {len_q[LEN_W-5:0], in_nibble};
          sum_d = sum_q + SUM_W'(in_nibble);
          if (idx_q == 2'd2) begin
            idx_d = '0;
            if ((len_d == '0) || (len_d > LEN_W'(MAX_WORDS))) begin
              state_d = ERROR;
              error_d = 1'b1;
            end else begin
              state_d = DATA;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      DATA: begin
        if (accept_c) begin
          word_d = {word_q[WORD_WIDTH-5:0], in_nibble};
          sum_d  = sum_q + SUM_W'(in_nibble);
          if (idx_q == 2'd3) begin
            idx_d     = '0;
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
            wr_data_d = word_d;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      // Single-cycle strobe; the count advances at the edge that ends it.
      WRITE: begin
        cnt_d = cnt_inc_c;
        if (LEN_W'(cnt_inc_c) == len_q) begin
          state_d = CHK;
        end else begin
          state_d = DATA;
        end
      end

      CHK: begin
        if (accept_c) begin
          if (idx_q == 2'd0) begin
            chk_hi_d = in_nibble;
            idx_d    = 2'd1;
          end else begin
            idx_d = '0;
            if ({chk_hi_q, in_nibble} == sum_q) begin
              state_d = DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end else begin
              state_d = ERROR;
              error_d = 1'b1;
              hold_d  = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
  end

  assign out_nibble_ready = ready_q;
  assign out_wr_en        = wr_en_q;
  assign out_wr_addr      = wr_addr_q;
  assign out_wr_data      = wr_data_q;
  assign out_cpu_hold     = hold_q;
  assign out_done         = done_q;
  assign out_error        = error_q;
  assign out_word_count   = cnt_q;

endmodule

// File: tb/tb_code_memory_loader.sv
// Directed self-checking bench for code_memory_loader.
module tb_code_memory_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_start = 1'b0;
  logic [3:0]  in_nibble = 4'h0;
  logic        in_nibble_valid = 1'b0;
  logic        out_nibble_ready;
  logic        out_wr_en;
  logic [8:0]  out_wr_addr;
  logic [15:0] out_wr_data;
  logic        out_cpu_hold;
  logic        out_done;
  logic        out_error;
  logic [9:0]  out_word_count;

  int n_assert = 0;
  int n_fail   = 0;
  int rdy_bad  = 0;
  logic [8:0]  wa[$];
  logic [15:0] wd[$];
  logic [15:0] wmem[512];

  code_memory_loader dut (
    .clk              (clk),
    .rst              (rst),
    .in_start         (in_start),
    .in_nibble        (in_nibble),
    .in_nibble_valid  (in_nibble_valid),
    .out_nibble_ready (out_nibble_ready),
    .out_wr_en        (out_wr_en),
    .out_wr_addr      (out_wr_addr),
    .out_wr_data      (out_wr_data),
    .out_cpu_hold     (out_cpu_hold),
    .out_done         (out_done),
    .out_error        (out_error),
    .out_word_count   (out_word_count)
  );

  always #5 clk = ~clk;

  // Write-port monitor; also flags ready seen high during a write strobe.
  always @(negedge clk) begin
    if (out_wr_en) begin
      wa.push_back(out_wr_addr);
      wd.push_back(out_wr_data);
      if (out_nibble_ready) rdy_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    rdy_bad = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    in_start = 1'b1;
    @(posedge clk);
    #1;
    in_start = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n, input int gap);
    int t;
    t = 0;
    if (gap > 0) begin
      in_nibble_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_nibble = n;
    in_nibble_valid = 1'b1;
    while (!out_nibble_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'(t), 32'(0));
    @(posedge clk);
    #1;
    in_nibble_valid = 1'b0;
  endtask

  task automatic send_load(input int n, input logic [7:0] ck, input bit stall);
    logic [11:0] len;
    logic [15:0] w;
    len = 12'(n);
    for (int i = 2; i >= 0; i--) send_nib(len[i*4 +: 4], stall ? int'($urandom_range(0, 2)) : 0);
    for (int k = 0; k < n; k++) begin
      w = wmem[k];
      for (int i = 3; i >= 0; i--) send_nib(w[i*4 +: 4], stall ? int'($urandom_range(0, 2)) : 0);
    end
    send_nib(ck[7:4], stall ? int'($urandom_range(0, 2)) : 0);
    send_nib(ck[3:0], stall ? int'($urandom_range(0, 2)) : 0);
  endtask

  function automatic logic [7:0] stream_sum(input int n);
    logic [11:0] len;
    logic [15:0] w;
    logic [7:0]  s;
    len = 12'(n);
    s = 8'(len[11:8]) + 8'(len[7:4]) + 8'(len[3:0]);
    for (int k = 0; k < n; k++) begin
      w = wmem[k];
      s = s + 8'(w[15:12]) + 8'(w[11:8]) + 8'(w[7:4]) + 8'(w[3:0]);
    end
    return s;
  endfunction

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({out_wr_en, out_nibble_ready, out_cpu_hold, out_done, out_error, out_word_count}), 32'(0));
    check("reset_bus", 32'({out_wr_addr, out_wr_data}), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Test 1: N=2, good checksum
    wmem[0] = 16'h1234;
    wmem[1] = 16'hABCD;
    clear_log();
    do_start();
    check("t1_hold_in_len", 32'(out_cpu_hold), 32'(1));
    check("t1_ready_in_len", 32'(out_nibble_ready), 32'(1));
    send_load(2, 8'h3A, 1'b0);
    check("t1_done", 32'(out_done), 32'(1));
    check("t1_hold", 32'(out_cpu_hold), 32'(0));
    check("t1_error", 32'(out_error), 32'(0));
    check("t1_count", 32'(out_word_count), 32'(2));
    check("t1_nwrites", 32'(wa.size()), 32'(2));
    check("t1_w0", 32'({wa[0], wd[0]}), 32'({9'h000, 16'h1234}));
    check("t1_w1", 32'({wa[1], wd[1]}), 32'({9'h001, 16'hABCD}));
    check("t1_bus_hold", 32'({out_wr_en, out_wr_addr, out_wr_data}), 32'({1'b0, 9'h001, 16'hABCD}));
    check("t1_ready_done", 32'(out_nibble_ready), 32'(0));

    // Test 2: bad checksum; a valid nibble during the start pulse must not be taken
    clear_log();
    in_nibble = 4'h0;
    in_nibble_valid = 1'b1;
    do_start();
    send_load(2, 8'h3B, 1'b0);
    check("t2_error", 32'(out_error), 32'(1));
    check("t2_hold", 32'(out_cpu_hold), 32'(1));
    check("t2_done", 32'(out_done), 32'(0));
    check("t2_nwrites", 32'(wa.size()), 32'(2));
    check("t2_w1", 32'({wa[1], wd[1]}), 32'({9'h001, 16'hABCD}));

    // Test 3: illegal lengths 0 and 513
    clear_log();
    do_start();
    send_nib(4'h0, 0);
    send_nib(4'h0, 0);
    send_nib(4'h0, 0);
    check("t3_len0_error", 32'(out_error), 32'(1));
    check("t3_len0_hold", 32'(out_cpu_hold), 32'(1));
    check("t3_len0_ready", 32'(out_nibble_ready), 32'(0));
    do_start();
    check("t3_restart_clears", 32'(out_error), 32'(0));
    send_nib(4'h2, 0);
    send_nib(4'h0, 0);
    send_nib(4'h1, 0);
    check("t3_len201_error", 32'(out_error), 32'(1));
    check("t3_nwrites", 32'(wa.size()), 32'(0));
    check("t3_count", 32'(out_word_count), 32'(0));

    // Test 4: test 1 stream with random valid gaps
    clear_log();
    do_start();
    send_load(2, 8'h3A, 1'b1);
    check("t4_done", 32'(out_done), 32'(1));
    check("t4_count", 32'(out_word_count), 32'(2));
    check("t4_w0", 32'({wa[0], wd[0]}), 32'({9'h000, 16'h1234}));
    check("t4_w1", 32'({wa[1], wd[1]}), 32'({9'h001, 16'hABCD}));
    check("t4_ready_in_write", 32'(rdy_bad), 32'(0));

    // Test 5: reset after 6 data nibbles, then a clean reload
    do_start();
    send_nib(4'h0, 0);
    send_nib(4'h0, 0);
    send_nib(4'h2, 0);
    send_nib(4'h1, 0);
    send_nib(4'h2, 0);
    send_nib(4'h3, 0);
    send_nib(4'h4, 0);
    send_nib(4'hA, 0);
    send_nib(4'hB, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_ctrl", 32'({out_wr_en, out_nibble_ready, out_cpu_hold, out_done, out_error, out_word_count}), 32'(0));
    check("t5_rst_bus", 32'({out_wr_addr, out_wr_data}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    do_start();
    send_load(2, 8'h3A, 1'b0);
    check("t5_done", 32'(out_done), 32'(1));
    check("t5_nwrites", 32'(wa.size()), 32'(2));
    check("t5_w1", 32'({wa[1], wd[1]}), 32'({9'h001, 16'hABCD}));

    // Test 6: maximum length, word == address
    for (int k = 0; k < 512; k++) wmem[k] = 16'(k);
    clear_log();
    do_start();
    send_load(512, stream_sum(512), 1'b0);
    check("t6_done", 32'(out_done), 32'(1));
    check("t6_count", 32'(out_word_count), 32'(512));
    check("t6_nwrites", 32'(wa.size()), 32'(512));
    check("t6_last_addr", 32'(wa[511]), 32'(9'h1FF));
    bad = 0;
    for (int k = 0; k < wa.size(); k++) begin
      if (wa[k] !== 9'(k) || wd[k] !== 16'(k)) bad++;
    end
    check("t6_data_errors", 32'(bad), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
